// File: rtl/branch_pred_ctrl_if.sv
// branch_pred_ctrl_if: fetch/execute-side signals of the branch predictor and flush controller
interface branch_pred_ctrl_if #(
  parameter int CNT_W = 16
);
  logic pc_write;
  logic if_valid;
  logic [31:0] if_pc;
  logic [5:0] if_opcode;
  logic ex_valid;
  logic ex_branch;
  logic [31:0] ex_pc;
  logic ex_taken;
  logic ex_pred;
  logic predict;
  logic flush;
  logic flush_taken;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;
  modport master (
    output pc_write, if_valid, if_pc, if_opcode, ex_valid, ex_branch, ex_pc, ex_taken, ex_pred,
    input predict, flush, flush_taken, branch_cnt, mispred_cnt
  );
  modport slave (
    input pc_write, if_valid, if_pc, if_opcode, ex_valid, ex_branch, ex_pc, ex_taken, ex_pred,
    output predict, flush, flush_taken, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_pred_ctrl.sv
// branch_pred_ctrl: 2-bit saturating-counter branch predictor with mispredict flush control and statistics
module branch_pred_ctrl #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  branch_pred_ctrl_if.slave bus
);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state, state_nxt;
  logic [1:0] tbl [2**IDX_W];
  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [1:0] cur, upd;
  logic res, mis;
  logic flush, flush_nxt, flush_taken, flush_taken_nxt;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;
  logic unused_pc;
  assign if_idx = bus.if_pc[IDX_W+1:2];
  assign ex_idx = bus.ex_pc[IDX_W+1:2];
  assign unused_pc = ^{bus.if_pc[31:IDX_W+2], bus.if_pc[1:0], bus.ex_pc[31:IDX_W+2], bus.ex_pc[1:0]};
  // EX instructions seen during FLUSH are wrong-path and never resolve
  assign res = bus.ex_valid & bus.ex_branch & bus.pc_write & (state == IDLE) & ~reset;
  assign mis = res & (bus.ex_taken ^ bus.ex_pred);
  assign cur = tbl[ex_idx];
  assign upd = bus.ex_taken ? (&cur ? cur : cur + 2'd1) : (|cur ? cur - 2'd1 : cur);
  assign bus.predict = bus.if_valid & (bus.if_opcode == 6'b000100) & tbl[if_idx][1] & (state == IDLE);
  assign bus.flush = flush;
  assign bus.flush_taken = flush_taken;
  assign bus.branch_cnt = branch_cnt;
  assign bus.mispred_cnt = mispred_cnt;
  // a stalled PC cannot take the correction, so FLUSH holds until pc_write
  always_comb begin
    state_nxt = state;
    flush_nxt = flush;
    flush_taken_nxt = flush_taken;
    if (state == IDLE) begin
      state_nxt = mis ? FLUSH : IDLE;
      flush_nxt = mis;
      flush_taken_nxt = mis & bus.ex_taken;
    end else if (bus.pc_write) begin
      state_nxt = IDLE;
      flush_nxt = 1'b0;
      flush_taken_nxt = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      flush <= 1'b0;
      flush_taken <= 1'b0;
      branch_cnt <= '0;
      mispred_cnt <= '0;
      for (int i = 0; i < 2**IDX_W; i++) tbl[i] <= 2'b01;
    end else begin
      state <= state_nxt;
      flush <= flush_nxt;
      flush_taken <= flush_taken_nxt;
      if (res) tbl[ex_idx] <= upd;
      if (res && !(&branch_cnt)) branch_cnt <= branch_cnt + CNT_W'(1);
      if (mis && !(&mispred_cnt)) mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_pred_ctrl.sv
// tb_branch_pred_ctrl: randomized and directed checks against a behavioural predictor model
module tb_branch_pred_ctrl;
  localparam int CNT_W = 4;
  localparam int MAXC = 15;
  logic clk = 1'b0;
  logic reset;
  int vectors = 0;
  int miscompares = 0;
  int m_tbl [16];
  int m_br, m_mis;
  bit m_fl, m_ft;
  bit exp_p;
  logic obs_p;
  branch_pred_ctrl_if #(.CNT_W(CNT_W)) bus ();
  branch_pred_ctrl #(.IDX_W(4), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic step(input bit r, input bit pw, input bit iv, input logic [31:0] ipc, input logic [5:0] op,
                      input bit ev, input bit eb, input logic [31:0] epc, input bit et, input bit ep);
    int k;
    reset = r; bus.pc_write = pw; bus.if_valid = iv; bus.if_pc = ipc; bus.if_opcode = op;
    bus.ex_valid = ev; bus.ex_branch = eb; bus.ex_pc = epc; bus.ex_taken = et; bus.ex_pred = ep;
    #2;
    obs_p = bus.predict;
    exp_p = iv && op == 6'b000100 && !m_fl && m_tbl[ipc[5:2]] >= 2;
    @(posedge clk);
    k = int'(epc[5:2]);
    if (r) begin
      foreach (m_tbl[i]) m_tbl[i] = 1;
      m_br = 0; m_mis = 0; m_fl = 0; m_ft = 0;
    end else if (!m_fl) begin
      if (ev && eb && pw) begin
        m_br = (m_br < MAXC) ? m_br + 1 : MAXC;
        m_tbl[k] = et ? ((m_tbl[k] < 3) ? m_tbl[k] + 1 : 3) : ((m_tbl[k] > 0) ? m_tbl[k] - 1 : 0);
        if (et != ep) begin
          m_mis = (m_mis < MAXC) ? m_mis + 1 : MAXC;
          m_fl = 1; m_ft = et;
        end
      end
    end else if (pw) begin
      m_fl = 0; m_ft = 0;
    end
    #1;
  endtask
  task automatic nop(input bit pw);
    step(0, pw, 0, 32'h0, 6'h0, 0, 0, 32'h0, 0, 0);
  endtask
  task automatic resolve(input logic [31:0] pc, input bit et, input bit ep);
    step(0, 1, 0, 32'h0, 6'h0, 1, 1, pc, et, ep);
  endtask
  task automatic probe(input logic [31:0] pc);
    step(0, 1, 1, pc, 6'b000100, 0, 0, 32'h0, 0, 0);
  endtask
  task automatic test_reset;
    step(1, 1, 0, 32'h0, 6'h0, 0, 0, 32'h0, 0, 0);
    probe(32'h40);
    vectors++; if (obs_p !== 1'b0) begin miscompares++; $display("FAIL reset_predict: got %b want 0", obs_p); end
    vectors++; if (bus.flush !== 1'b0) begin miscompares++; $display("FAIL reset_flush: got %b want 0", bus.flush); end
    vectors++; if (bus.branch_cnt !== 4'd0 || bus.mispred_cnt !== 4'd0) begin
      miscompares++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus.branch_cnt, bus.mispred_cnt); end
  endtask
  task automatic test_train;
    for (int n = 0; n < 2; n++) begin
      resolve(32'h40, 1, 0);
      vectors++; if (bus.flush !== 1'b1 || bus.flush_taken !== 1'b1) begin
        miscompares++; $display("FAIL train_flush%0d: got %b/%b want 1/1", n, bus.flush, bus.flush_taken); end
      nop(1);
      vectors++; if (bus.flush !== 1'b0) begin miscompares++; $display("FAIL train_unflush%0d: got %b want 0", n, bus.flush); end
    end
    probe(32'h40);
    vectors++; if (obs_p !== 1'b1) begin miscompares++; $display("FAIL train_predict: got %b want 1", obs_p); end
    vectors++; if (bus.branch_cnt !== 4'd2 || bus.mispred_cnt !== 4'd2) begin
      miscompares++; $display("FAIL train_cnt: got %0d/%0d want 2/2", bus.branch_cnt, bus.mispred_cnt); end
  endtask
  task automatic test_correct;
    resolve(32'h40, 1, 1);
    vectors++; if (bus.flush !== 1'b0) begin miscompares++; $display("FAIL correct_flush: got %b want 0", bus.flush); end
    vectors++; if (bus.branch_cnt !== 4'd3 || bus.mispred_cnt !== 4'd2) begin
      miscompares++; $display("FAIL correct_cnt: got %0d/%0d want 3/2", bus.branch_cnt, bus.mispred_cnt); end
    probe(32'h40);
    vectors++; if (obs_p !== 1'b1 || m_tbl[0] != 3) begin miscompares++; $display("FAIL correct_predict: got %b want 1", obs_p); end
  endtask
  task automatic test_stall;
    resolve(32'h40, 0, 1);
    for (int n = 0; n < 3; n++) begin
      vectors++; if (bus.flush !== 1'b1 || bus.flush_taken !== 1'b0) begin
        miscompares++; $display("FAIL stall_hold%0d: got %b/%b want 1/0", n, bus.flush, bus.flush_taken); end
      nop(0);
    end
    vectors++; if (bus.flush !== 1'b1) begin miscompares++; $display("FAIL stall_last: got %b want 1", bus.flush); end
    nop(1);
    vectors++; if (bus.flush !== 1'b0) begin miscompares++; $display("FAIL stall_release: got %b want 0", bus.flush); end
  endtask
  task automatic test_flush_ignore;
    int br, mi;
    resolve(32'h44, 1, 1);
    resolve(32'h44, 1, 1);
    resolve(32'h48, 1, 0);
    br = m_br; mi = m_mis;
    step(0, 1, 1, 32'h44, 6'b000100, 1, 1, 32'h44, 0, 1);
    vectors++; if (obs_p !== 1'b0) begin miscompares++; $display("FAIL flush_predict: got %b want 0", obs_p); end
    vectors++; if (bus.flush !== 1'b0) begin miscompares++; $display("FAIL flush_exit: got %b want 0", bus.flush); end
    vectors++; if (int'(bus.branch_cnt) != br || int'(bus.mispred_cnt) != mi) begin
      miscompares++; $display("FAIL flush_cnt: got %0d/%0d want %0d/%0d", bus.branch_cnt, bus.mispred_cnt, br, mi); end
    probe(32'h44);
    vectors++; if (obs_p !== 1'b1) begin miscompares++; $display("FAIL flush_table: got %b want 1", obs_p); end
  endtask
  task automatic test_same_cycle;
    step(1, 1, 0, 32'h0, 6'h0, 0, 0, 32'h0, 0, 0);
    step(0, 1, 1, 32'h80, 6'b000100, 1, 1, 32'h80, 1, 1);
    vectors++; if (obs_p !== 1'b0) begin miscompares++; $display("FAIL same_now: got %b want 0", obs_p); end
    probe(32'h80);
    vectors++; if (obs_p !== 1'b1) begin miscompares++; $display("FAIL same_next: got %b want 1", obs_p); end
    step(0, 1, 1, 32'h80, 6'b000010, 0, 0, 32'h0, 0, 0);
    vectors++; if (obs_p !== 1'b0) begin miscompares++; $display("FAIL jump_predict: got %b want 0", obs_p); end
  endtask
  task automatic test_reset_mid_flush;
    resolve(32'h50, 1, 0);
    vectors++; if (bus.flush !== 1'b1) begin miscompares++; $display("FAIL midflush_set: got %b want 1", bus.flush); end
    step(1, 0, 0, 32'h0, 6'h0, 1, 1, 32'h50, 1, 0);
    vectors++; if (bus.flush !== 1'b0 || bus.flush_taken !== 1'b0 || bus.mispred_cnt !== 4'd0) begin
      miscompares++; $display("FAIL midflush_reset: got %b/%b/%0d want 0/0/0", bus.flush, bus.flush_taken, bus.mispred_cnt); end
  endtask
  task automatic test_saturation;
    for (int n = 0; n < 20; n++) begin
      bit t = 1'($urandom);
      resolve({26'h0, 4'($urandom), 2'b00}, t, !t);
      nop(1);
    end
    vectors++; if (bus.mispred_cnt !== 4'hF || bus.branch_cnt !== 4'hF) begin
      miscompares++; $display("FAIL sat_cnt: got %0d/%0d want 15/15", bus.branch_cnt, bus.mispred_cnt); end
  endtask
  task automatic test_random;
    step(1, 1, 0, 32'h0, 6'h0, 0, 0, 32'h0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      int sel = $urandom_range(0, 3);
      op = (sel < 2) ? 6'b000100 : (sel == 2) ? 6'b000010 : 6'($urandom);
      step(0, $urandom_range(0, 4) != 0, 1'($urandom), {26'h0, 4'($urandom), 2'($urandom)}, op,
           1'($urandom), 1'($urandom), {26'h0, 4'($urandom), 2'($urandom)}, 1'($urandom), 1'($urandom));
      vectors++; if (obs_p !== exp_p) begin miscompares++; $display("FAIL rand_predict[%0d]: got %b want %b", n, obs_p, exp_p); end
      vectors++; if (bus.flush !== m_fl || bus.flush_taken !== m_ft) begin
        miscompares++; $display("FAIL rand_flush[%0d]: got %b/%b want %b/%b", n, bus.flush, bus.flush_taken, m_fl, m_ft); end
      vectors++; if (int'(bus.branch_cnt) != m_br || int'(bus.mispred_cnt) != m_mis) begin
        miscompares++; $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", n, bus.branch_cnt, bus.mispred_cnt, m_br, m_mis); end
    end
  endtask
  initial begin
    foreach (m_tbl[i]) m_tbl[i] = 1;
    m_br = 0; m_mis = 0; m_fl = 0; m_ft = 0;
    test_reset;
    test_train;
    test_correct;
    test_stall;
    test_flush_ignore;
    test_same_cycle;
    test_reset_mid_flush;
    test_saturation;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
